// File: rtl/mips_irq_sched_pkg.sv
// rtl/mips_irq_sched_pkg.sv - register map, dmem op codes and FSM states for the interrupt scheduler
package mips_irq_sched_pkg;

  localparam logic [3:0] DMEM_NOP = 4'd0;
  localparam logic [3:0] DMEM_LW  = 4'd4;
  localparam logic [3:0] DMEM_SW  = 4'd8;

  localparam logic [31:0] IRQ_EN_ADDR   = 32'h0000_2000;
  localparam logic [31:0] IRQ_PEND_ADDR = 32'h0000_2004;
  localparam logic [31:0] IRQ_CUR_ADDR  = 32'h0000_2008;
  localparam logic [31:0] IRQ_VEC_ADDR  = 32'h0000_2010;

  typedef enum logic [1:0] {
    IRQ_S_IDLE = 2'd0,
    IRQ_S_REQ  = 2'd1,
    IRQ_S_SVC  = 2'd2
  } irq_state_t;

  function automatic logic [31:0] irq_vec_addr(input int i);
    return IRQ_VEC_ADDR + 32'(i * 4);
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// rtl/irq_edge_latch.sv - per-source rising-edge detect and pending flop with write-1-to-clear
module irq_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic pend_nxt
);

  logic req_d;
  logic pend_q;

  // A new edge in the same cycle as a clear keeps the bit set.
  assign pend_nxt = (req & ~req_d) | (pend_q & ~clr);
  assign pend     = pend_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_d  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      req_d  <= req;
      pend_q <= pend_nxt;
    end
  end

endmodule

// File: rtl/mips_irq_sched.sv
// rtl/mips_irq_sched.sv - interrupt scheduler on the mips789 dmem bus; IRQ_SCHED_RR_EN selects round-robin arbitration
module mips_irq_sched
  import mips_irq_sched_pkg::*;
#(
  parameter int          NSRC    = 3,
  parameter logic [31:0] VEC_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     addr,
  input  logic [31:0]     din,
  input  logic [3:0]      mem_ctl,
  output logic [31:0]     dout,
  input  logic [NSRC-1:0] src_req,
  input  logic            irq_ack_i,
  input  logic            irq_done_i,
  output logic            irq_req_o,
  output logic [31:0]     irq_addr_o
);

  logic            is_sw;
  logic            is_lw;
  logic [NSRC:0]   en_q;
  logic [NSRC:0]   en_nxt;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] req_vec;
  logic [31:0]     vec_q [NSRC];
  logic [31:0]     cur_vec;
  logic [31:0]     rd_data;
  logic [31:0]     dout_q;
  irq_state_t      state_q;
  irq_state_t      state_nxt;
  logic [2:0]      gnt_q;
  logic [2:0]      gnt_sel;
  logic            gnt_found;
  logic            gnt_load;
  logic            gnt_pend_nxt;

  assign is_sw  = (mem_ctl == DMEM_SW);
  assign is_lw  = (mem_ctl == DMEM_LW);
  assign en_nxt = (is_sw && addr == IRQ_EN_ADDR) ? din[NSRC:0] : en_q;
  assign w1c    = (is_sw && addr == IRQ_PEND_ADDR) ? din[NSRC-1:0] : '0;
  assign clr    = w1c | ack_clr;
  assign req_vec = pend & en_q[NSRC:1];

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_edge_latch u_latch (
      .clk      (clk),
      .rst      (rst),
      .req      (src_req[i]),
      .clr      (clr[i]),
      .pend     (pend[i]),
      .pend_nxt (pend_nxt[i])
    );
  end

  // Decode the granted id with compares so no variable index is wider than the vectors.
  always_comb begin
    ack_clr      = '0;
    gnt_pend_nxt = 1'b0;
    cur_vec      = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (gnt_q == 3'(i)) begin
        ack_clr[i]   = (state_q == IRQ_S_REQ) && irq_ack_i;
        gnt_pend_nxt = pend_nxt[i];
        cur_vec      = vec_q[i];
      end
    end
  end

`ifdef IRQ_SCHED_RR_EN
  logic [2:0] rr_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= 3'(NSRC - 1);
    end else if (state_q == IRQ_S_REQ && irq_ack_i) begin
      rr_ptr_q <= gnt_q;
    end
  end
`endif

  always_comb begin : arb
    int cand;
    gnt_sel   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
`ifdef IRQ_SCHED_RR_EN
      cand = int'(rr_ptr_q) + 1 + k;
      if (cand >= NSRC) cand = cand - NSRC;
`else
      cand = k;
`endif
      for (int j = 0; j < NSRC; j++) begin
        if (j == cand && req_vec[j] && !gnt_found) begin
          gnt_found = 1'b1;
          gnt_sel   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    gnt_load  = 1'b0;
    case (state_q)
      IRQ_S_IDLE: begin
        if (en_q[0] && gnt_found) begin
          state_nxt = IRQ_S_REQ;
          gnt_load  = 1'b1;
        end
      end
      IRQ_S_REQ: begin
        // Withdraw looks at next-cycle enable/pending so a bus write drops the request immediately.
        if (irq_ack_i) state_nxt = IRQ_S_SVC;
        else if (!en_nxt[0] || !gnt_pend_nxt) state_nxt = IRQ_S_IDLE;
      end
      IRQ_S_SVC: begin
        if (irq_done_i) state_nxt = IRQ_S_IDLE;
      end
      default: state_nxt = IRQ_S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (is_lw) begin
      if (addr == IRQ_EN_ADDR) rd_data[NSRC:0] = en_q;
      if (addr == IRQ_PEND_ADDR) rd_data[NSRC-1:0] = pend;
      if (addr == IRQ_CUR_ADDR) begin
        rd_data[31]  = (state_q == IRQ_S_SVC);
        rd_data[2:0] = gnt_q;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (addr == irq_vec_addr(i)) rd_data = vec_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IRQ_S_IDLE;
      gnt_q   <= '0;
      en_q    <= '0;
      dout_q  <= '0;
      for (int i = 0; i < NSRC; i++) vec_q[i] <= VEC_RST;
    end else begin
      state_q <= state_nxt;
      en_q    <= en_nxt;
      dout_q  <= rd_data;
      if (gnt_load) gnt_q <= gnt_sel;
      for (int i = 0; i < NSRC; i++) begin
        if (is_sw && addr == irq_vec_addr(i)) vec_q[i] <= din;
      end
    end
  end

  assign dout       = dout_q;
  assign irq_req_o  = (state_q == IRQ_S_REQ);
  assign irq_addr_o = (state_q == IRQ_S_REQ) ? cur_vec : 32'h0;

endmodule
